// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, byte indexing, round FSM encoding and the
// GF(2^8) helpers used by both the forward and inverse round engines.
package aes_pkg;

    localparam int STATE_W   = 128;
    localparam int BYTE_W    = 8;
    localparam int COL_W     = 32;
    localparam int NUM_BYTES = 16;
    localparam int NUM_ROWS  = 4;
    localparam int NUM_COLS  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SB,
        ST_SR,
        ST_MC,
        ST_ARK,
        ST_DONE
    } round_state_e;

    // Byte 0 is the most significant byte of the 128-bit vector.
    function automatic int byte_lsb(input int idx);
        return STATE_W - BYTE_W * (idx + 1);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Column is {row0, row1, row2, row3}, row0 in the top byte.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse (x^254) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31;
    logic [7:0] x62, x63, x126, x127, inv;

    // Square-and-multiply chain; 0 maps to 0, which the affine step needs.
    always_comb begin
        x2   = gf_mul(in_i, in_i);
        x3   = gf_mul(x2, in_i);
        x6   = gf_mul(x3, x3);
        x7   = gf_mul(x6, in_i);
        x14  = gf_mul(x7, x7);
        x15  = gf_mul(x14, in_i);
        x30  = gf_mul(x15, x15);
        x31  = gf_mul(x30, in_i);
        x62  = gf_mul(x31, x31);
        x63  = gf_mul(x62, in_i);
        x126 = gf_mul(x63, x63);
        x127 = gf_mul(x126, in_i);
        inv  = gf_mul(x127, x127);
    end

    assign out_o = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;

endmodule

// File: rtl/aes_enc_round.sv
// Forward AES-128 round engine: one round per start, one stage per cycle,
// result registered on leaving ARK and flagged by a one-cycle rounds_done.
module aes_enc_round
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_rounds,
    input  logic               initial_round,
    input  logic               final_round,
    input  logic [STATE_W-1:0] message_in,
    input  logic [STATE_W-1:0] new_key,
    output logic [STATE_W-1:0] message_out,
    output logic               rounds_done,
    output logic               busy
);

    round_state_e       state_q, state_d;
    logic [STATE_W-1:0] data_q, data_d;
    logic [STATE_W-1:0] key_q, key_d;
    logic [STATE_W-1:0] out_q, out_d;
    logic               fin_q, fin_d;

    logic [STATE_W-1:0] sb_data, sr_data, mc_data;

    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_sb
        localparam int LSB = byte_lsb(i);
        aes_sbox u_sbox (
            .in_i  (data_q[LSB +: BYTE_W]),
            .out_o (sb_data[LSB +: BYTE_W])
        );
    end

    // Row r rotates left by r columns: dest (r,c) takes source (r,(c+r)%4).
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_sr_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_sr_col
            localparam int DST = byte_lsb(r + NUM_ROWS * c);
            localparam int SRC = byte_lsb(r + NUM_ROWS * ((c + r) % NUM_COLS));
            assign sr_data[DST +: BYTE_W] = data_q[SRC +: BYTE_W];
        end
    end

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_mc
        localparam int LSB = STATE_W - COL_W * (c + 1);
        assign mc_data[LSB +: COL_W] = mix_column(data_q[LSB +: COL_W]);
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        key_d   = key_q;
        out_d   = out_q;
        fin_d   = fin_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable_rounds) begin
                    data_d  = message_in;
                    key_d   = new_key;
                    // Both flags set falls back to the initial round.
                    fin_d   = final_round & ~initial_round;
                    state_d = initial_round ? ST_ARK : ST_SB;
                end
            end
            ST_SB: begin
                data_d  = sb_data;
                state_d = ST_SR;
            end
            ST_SR: begin
                data_d  = sr_data;
                state_d = fin_q ? ST_ARK : ST_MC;
            end
            ST_MC: begin
                data_d  = mc_data;
                state_d = ST_ARK;
            end
            ST_ARK: begin
                data_d  = data_q ^ key_q;
                out_d   = data_q ^ key_q;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            key_q   <= '0;
            out_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            out_q   <= out_d;
            fin_q   <= fin_d;
        end
    end

    always @(posedge clk) begin
        if (!rst && state_q == ST_IDLE && enable_rounds)
            assert (!(initial_round && final_round))
            else $warning("aes_enc_round: initial_round and final_round both set, running as initial round");
    end

    assign message_out = out_q;
    assign rounds_done = (state_q == ST_DONE);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_enc_round.sv
// Bench for aes_enc_round: FIPS-197 vectors, corner cases and random rounds
// checked every cycle against a byte-matrix AES round model.
module tb_aes_enc_round;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable_rounds;
    logic         initial_round;
    logic         final_round;
    logic [127:0] message_in;
    logic [127:0] new_key;
    logic [127:0] message_out;
    logic         rounds_done;
    logic         busy;

    always #5 clk = ~clk;

    aes_enc_round dut (
        .clk           (clk),
        .rst           (rst),
        .enable_rounds (enable_rounds),
        .initial_round (initial_round),
        .final_round   (final_round),
        .message_in    (message_in),
        .new_key       (new_key),
        .message_out   (message_out),
        .rounds_done   (rounds_done),
        .busy          (busy)
    );

    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    logic [7:0]   sb [256];
    logic [127:0] rk [11];

    localparam logic [127:0] PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R0   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] KEY1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] S9   = 128'heb40f21e592e38848ba113e71bc342d2;
    localparam logic [127:0] K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic hi;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input int d);
        case (d)
            0: return 8'h02;
            1: return 8'h03;
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [127:0] k,
                                               input bit init, input bit fin);
        logic [7:0] a [4][4];
        logic [7:0] t [4][4];
        logic [7:0] acc;
        logic [127:0] v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                a[r][c] = s[127 - 8 * (r + 4 * c) -: 8];
        if (!init) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t[r][c] = sb[a[r][(c + r) % 4]];
            a = t;
            if (!fin) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        acc = 8'h00;
                        for (int q = 0; q < 4; q++)
                            acc = acc ^ gmul(coef((q - r + 4) % 4), a[q][c]);
                        t[r][c] = acc;
                    end
                a = t;
            end
        end
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[127 - 8 * (r + 4 * c) -: 8] = a[r][c];
        return v ^ k;
    endfunction

    task automatic build_tables();
        logic [7:0] inv, o, cst, xb;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rcon;
        cst = 8'h63;
        for (int x = 0; x < 256; x++) begin
            xb = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(xb, y[7:0]) == 8'h01) inv = y[7:0];
            for (int i = 0; i < 8; i++)
                o[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8] ^ cst[i];
            sb[x] = o;
        end
        for (int i = 0; i < 4; i++) w[i] = KEY0[127 - 32 * i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: edges since the accepted start (-1 when idle) and the result due.
    int           m_k = -1;
    int           m_lat = 0;
    logic [127:0] m_res = '0;
    logic [127:0] m_out = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_k   <= -1;
            m_out <= '0;
        end else if (m_k < 0) begin
            if (enable_rounds) begin
                m_k   <= 0;
                m_lat <= initial_round ? 2 : (final_round ? 4 : 5);
                m_res <= ref_round(message_in, new_key, initial_round,
                                   final_round && !initial_round);
            end
        end else if (m_k == m_lat - 1) begin
            m_k <= -1;
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_lat - 1) m_out <= m_res;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {127'd0, busy}, {127'd0, (m_k >= 0)});
            check("rounds_done", {127'd0, rounds_done}, {127'd0, (m_k >= 0 && m_k == m_lat - 1)});
            if (m_k < 0 || m_k == m_lat - 1)
                check("message_out", message_out, m_out);
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Caller guarantees the DUT is idle; returns on the cycle after DONE.
    task automatic run_round(input bit init, input bit fin, input logic [127:0] msg,
                             input logic [127:0] key, input int lat, input logic [127:0] exp,
                             input bit hold_en, input string name, output logic [127:0] res);
        int edges;
        @(negedge clk);
        enable_rounds = 1'b1;
        initial_round = init;
        final_round   = fin;
        message_in    = msg;
        new_key       = key;
        @(negedge clk);
        edges = 1;
        if (!hold_en) enable_rounds = 1'b0;
        message_in    = rand128();
        new_key       = rand128();
        initial_round = $urandom_range(0, 1) == 1;
        final_round   = $urandom_range(0, 1) == 1;
        while (rounds_done !== 1'b1 && edges < 12) begin
            @(negedge clk);
            edges++;
            if (hold_en) message_in = rand128();
        end
        check({name, " latency"}, edges, lat);
        check({name, " result"}, message_out, exp);
        res = message_out;
        enable_rounds = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] s, msg, key;
        bit ini, fin;
        rst = 1'b1;
        enable_rounds = 1'b0;
        initial_round = 1'b0;
        final_round = 1'b0;
        message_in = '0;
        new_key = '0;
        build_tables();
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset out", message_out, '0);
        check("reset busy", {127'd0, busy}, '0);
        check("reset done", {127'd0, rounds_done}, '0);
        rst = 1'b0;

        run_round(1, 0, PT, KEY0, 2, R0, 0, "initial", s);
        run_round(0, 0, R0, KEY1, 5, R1, 0, "middle1", s);
        run_round(0, 1, S9, K10, 4, CT, 0, "final", s);

        // Reset while the middle round sits in MC.
        @(negedge clk);
        enable_rounds = 1'b1; message_in = R0; new_key = KEY1;
        @(negedge clk); enable_rounds = 1'b0;
        @(negedge clk);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check("midrst out", message_out, '0);
        check("midrst done", {127'd0, rounds_done}, '0);
        rst = 1'b0;
        run_round(0, 0, R0, KEY1, 5, R1, 0, "after reset", s);

        // Reset and start in the same cycle.
        @(negedge clk);
        rst = 1'b1; enable_rounds = 1'b1;
        @(negedge clk);
        check("rst+start busy", {127'd0, busy}, '0);
        rst = 1'b0; enable_rounds = 1'b0;

        run_round(1, 0, PT, KEY0, 2, R0, 1, "hold initial", s);
        run_round(0, 0, R0, KEY1, 5, R1, 1, "hold middle", s);
        run_round(1, 1, PT, KEY0, 2, R0, 0, "both flags", s);

        s = PT;
        run_round(1, 0, s, rk[0], 2, ref_round(s, rk[0], 1, 0), 0, "cipher r0", s);
        for (int r = 1; r < 10; r++)
            run_round(0, 0, s, rk[r], 5, ref_round(s, rk[r], 0, 0), 0,
                      $sformatf("cipher r%0d", r), s);
        run_round(0, 1, s, rk[10], 4, CT, 0, "cipher", s);

        for (int n = 0; n < 40; n++) begin
            msg = rand128();
            key = rand128();
            ini = $urandom_range(0, 3) == 0;
            fin = !ini && $urandom_range(0, 2) == 0;
            run_round(ini, fin, msg, key, ini ? 2 : (fin ? 4 : 5), ref_round(msg, key, ini, fin),
                      $urandom_range(0, 1) == 1, $sformatf("random%0d", n), s);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
